weight_bulk_sequencer: RTL and testbench
========================================

WEIGHT_BULK_SEQUENCER -- requirements
Module: weight_bulk_sequencer

Interface
REQ-001 Parameter WEIGHT_WIDTH, default 16, meaning bits per synaptic weight.
REQ-002 Parameter ADDR_BITS, default 12, meaning weight memory address width (4096 synapses).
REQ-003 Parameter STREAM_WIDTH, default 32, meaning stream beat width (two weights per beat).
REQ-004 aclk  in  1  single clock for all logic.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 bulk_start  in  1  one-cycle request to begin a bulk load.
REQ-007 bulk_start_addr  in  ADDR_BITS  first weight address.
REQ-008 bulk_length  in  ADDR_BITS  number of weights to write; 0 means no-op.
REQ-009 bulk_done  out  1  one-cycle pulse when the load ends, normally or on error.
REQ-010 bulk_busy  out  1  high from the cycle after an accepted start until bulk_done.
REQ-011 bulk_error  out  1  sticky tlast-mismatch flag; cleared by the next accepted start.
REQ-012 s_axis_tdata  in  STREAM_WIDTH  packed weights: [15:0] first, [31:16] second.
REQ-013 s_axis_tvalid / s_axis_tlast  in  1 each  stream valid and end-of-packet.
REQ-014 s_axis_tready  out  1  stream ready.
REQ-015 host_we, host_rd_en  in  1 each  single-access requests from the AXI-Lite weight port.
REQ-016 host_addr  in  ADDR_BITS; host_wdata  in  WEIGHT_WIDTH  host access address and data.
REQ-017 mem_we, mem_rd_en  out  1 each; mem_addr  out  ADDR_BITS; mem_wdata  out  WEIGHT_WIDTH  arbitrated weight-memory port.
REQ-018 weights_written  out  16  count of bulk weights written since the last accepted start.

Function
REQ-019 All mem_* outputs SHALL be registered, with exactly 1 cycle of latency from the winning request.
REQ-020 Host requests SHALL have absolute priority: in any cycle with host_we or host_rd_en high, the host request drives mem_* next cycle and the sequencer write stalls with no state change.
REQ-021 If host_we and host_rd_en are both high, the write SHALL win and the read is dropped.
REQ-022 The FSM SHALL have states IDLE, FETCH, WRITE_LO, WRITE_HI and DONE.
REQ-023 IDLE: on bulk_start, latch address and length, clear bulk_error and weights_written, then go to FETCH; if length==0, go to DONE instead.
REQ-024 bulk_start outside IDLE SHALL be ignored.
REQ-025 FETCH: s_axis_tready=1 (tready=0 in every other state); on a tvalid&&tready beat, capture tdata and tlast, then go to WRITE_LO.
REQ-026 WRITE_LO and WRITE_HI: in a non-stalled cycle, write the low or high half at the current address, increment the address modulo 2^ADDR_BITS (4095 wraps to 0), decrement remaining and increment weights_written.
REQ-027 After a write, remaining==0 SHALL go to DONE; otherwise WRITE_LO goes to WRITE_HI, and WRITE_HI goes to FETCH.
REQ-028 For odd length, the high half of the final beat SHALL be discarded without a write.
REQ-029 Early tlast (captured on a beat that does not hold the final weight): finish that beat's writes, set bulk_error, then go to DONE; remaining weights are abandoned.
REQ-030 Missing tlast on the final beat: set bulk_error; completion proceeds normally.
REQ-031 DONE: assert bulk_done for one cycle, then go to IDLE.
REQ-032 Peak throughput SHALL be 2 weights per 3 cycles with no host traffic.

Reset
REQ-033 Asserting areset SHALL immediately, and mid-load if necessary, force IDLE and set every output to 0 (mem_*, bulk_done, bulk_busy, bulk_error, s_axis_tready, weights_written).
REQ-034 A load interrupted by reset SHALL be abandoned with no bulk_done pulse.

Structure
REQ-035 FSM state encodings and the weight-half-select constants SHALL reside in a shared package, snn_weight_pkg.
REQ-036 One sub-module SHALL be instantiated: weight_port_arbiter, the registered host-priority mux driving mem_*.

Verification
REQ-037 Load at addr=0x010, len=4 with beats 0x00020001 and 0x00040003 (tlast on the 2nd beat) -> writes 0x0001@0x010, 0x0002@0x011, 0x0003@0x012, 0x0004@0x013; one bulk_done pulse; bulk_error=0; weights_written=4.
REQ-038 addr=0xFFE, len=3 -> writes land at 0xFFE, 0xFFF and 0x000; the high half of the 2nd beat is not written.
REQ-039 host_we pulsed for 3 cycles during WRITE_LO -> the three host writes appear on mem_* in order; the bulk write is delayed 3 cycles; total bulk writes unchanged.
REQ-040 len=6 with tlast on the 1st beat -> 2 writes, bulk_error=1, bulk_done pulses, weights_written=2.
REQ-041 len=0 -> bulk_done 2 cycles after start, no mem_we, tready never asserted.
REQ-042 areset asserted after 1 write of a len=8 load -> all outputs 0 asynchronously, no bulk_done; a new start afterwards completes normally.

Source files
------------

// File: rtl/snn_weight_pkg.sv
// Shared definitions for the weight bulk sequencer: FSM state encodings,
// weight-half select constants and the memory-port grant encoding.
package snn_weight_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WRITE_LO = 3'd2,
        ST_WRITE_HI = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_t;

    // Which half of a captured stream beat is being written
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Winner of the weight-memory port in a given cycle
    typedef enum logic [1:0] {
        GRANT_NONE    = 2'd0,
        GRANT_HOST_WR = 2'd1,
        GRANT_HOST_RD = 2'd2,
        GRANT_SEQ     = 2'd3
    } grant_t;

endpackage

// File: rtl/weight_port_arbiter.sv
// Registered host-priority mux for the weight-memory port. Host writes beat
// host reads, host reads beat sequencer writes, and the result shows up on
// mem_* exactly one cycle after the winning request.
module weight_port_arbiter
    import snn_weight_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 16,
    parameter int ADDR_BITS    = 12
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic                    i_host_we,
    input  logic                    i_host_rd_en,
    input  logic [ADDR_BITS-1:0]    i_host_addr,
    input  logic [WEIGHT_WIDTH-1:0] i_host_wdata,
    input  logic                    i_seq_we,
    input  logic [ADDR_BITS-1:0]    i_seq_addr,
    input  logic [WEIGHT_WIDTH-1:0] i_seq_wdata,
    output logic                    o_mem_we,
    output logic                    o_mem_rd_en,
    output logic [ADDR_BITS-1:0]    o_mem_addr,
    output logic [WEIGHT_WIDTH-1:0] o_mem_wdata
);

    grant_t w_grant;

    // Pick this cycle's winner; a simultaneous host read is dropped when the host writes
    always_comb begin
        w_grant = GRANT_NONE;
        if (i_host_we) begin
            w_grant = GRANT_HOST_WR;
        end else if (i_host_rd_en) begin
            w_grant = GRANT_HOST_RD;
        end else if (i_seq_we) begin
            w_grant = GRANT_SEQ;
        end
    end

    // Register the winning request onto the memory port; idle cycles drive zeros
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            o_mem_we    <= 1'b0;
            o_mem_rd_en <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (w_grant)
                GRANT_HOST_WR: begin
                    o_mem_we    <= 1'b1;
                    o_mem_rd_en <= 1'b0;
                    o_mem_addr  <= i_host_addr;
                    o_mem_wdata <= i_host_wdata;
                end
                GRANT_HOST_RD: begin
                    o_mem_we    <= 1'b0;
                    o_mem_rd_en <= 1'b1;
                    o_mem_addr  <= i_host_addr;
                    o_mem_wdata <= '0;
                end
                GRANT_SEQ: begin
                    o_mem_we    <= 1'b1;
                    o_mem_rd_en <= 1'b0;
                    o_mem_addr  <= i_seq_addr;
                    o_mem_wdata <= i_seq_wdata;
                end
                default: begin
                    o_mem_we    <= 1'b0;
                    o_mem_rd_en <= 1'b0;
                    o_mem_addr  <= '0;
                    o_mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/weight_bulk_sequencer.sv
// Bulk weight loader: pulls packed two-weight beats from an AXI-Stream slave
// and writes them to consecutive weight-memory addresses, yielding the memory
// port to host single accesses whenever they arrive.
module weight_bulk_sequencer
    import snn_weight_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 16,
    parameter int ADDR_BITS    = 12,
    parameter int STREAM_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    bulk_start,
    input  logic [ADDR_BITS-1:0]    bulk_start_addr,
    input  logic [ADDR_BITS-1:0]    bulk_length,
    output logic                    bulk_done,
    output logic                    bulk_busy,
    output logic                    bulk_error,
    input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    host_we,
    input  logic                    host_rd_en,
    input  logic [ADDR_BITS-1:0]    host_addr,
    input  logic [WEIGHT_WIDTH-1:0] host_wdata,
    output logic                    mem_we,
    output logic                    mem_rd_en,
    output logic [ADDR_BITS-1:0]    mem_addr,
    output logic [WEIGHT_WIDTH-1:0] mem_wdata,
    output logic [15:0]             weights_written
);

    seq_state_t               r_state;
    seq_state_t               w_next_state;

    logic [ADDR_BITS-1:0]     r_addr;
    logic [ADDR_BITS-1:0]     r_remaining;
    logic [STREAM_WIDTH-1:0]  r_beat;
    logic                     r_last;
    logic                     r_error;
    logic [15:0]              r_written;
    logic                     r_bulk_done;

    logic                     w_host_req;
    logic                     w_start;
    logic                     w_beat_accept;
    logic                     w_write_fire;
    logic                     w_final_write;
    logic                     w_beat_has_final;
    logic                     w_early_last;
    logic                     w_seq_we;
    logic                     w_half;
    logic [WEIGHT_WIDTH-1:0]  w_seq_wdata;

    assign w_host_req       = host_we | host_rd_en;
    assign w_start          = (r_state == ST_IDLE) && bulk_start;
    assign w_beat_accept    = (r_state == ST_FETCH) && s_axis_tvalid;
    assign w_write_fire     = w_seq_we && !w_host_req;
    assign w_final_write    = (r_remaining == ADDR_BITS'(1));
    assign w_beat_has_final = (r_remaining <= ADDR_BITS'(2));
    assign w_early_last     = (r_state == ST_WRITE_HI) && r_last && !w_final_write;
    assign w_seq_wdata      = (w_half == HALF_HI) ? r_beat[2*WEIGHT_WIDTH-1:WEIGHT_WIDTH]
                                                  : r_beat[WEIGHT_WIDTH-1:0];

    // State register; reset drops any load in progress straight back to idle
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; writes hold their state while the host owns the port
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bulk_start) begin
                    w_next_state = (bulk_length == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (s_axis_tvalid) begin
                    w_next_state = ST_WRITE_LO;
                end
            end
            ST_WRITE_LO: begin
                if (!w_host_req) begin
                    w_next_state = w_final_write ? ST_DONE : ST_WRITE_HI;
                end
            end
            ST_WRITE_HI: begin
                if (!w_host_req) begin
                    w_next_state = (w_final_write || r_last) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs: stream ready, busy flag and which half to write
    always_comb begin
        s_axis_tready = 1'b0;
        bulk_busy     = 1'b0;
        w_seq_we      = 1'b0;
        w_half        = HALF_LO;
        case (r_state)
            ST_FETCH: begin
                s_axis_tready = 1'b1;
                bulk_busy     = 1'b1;
            end
            ST_WRITE_LO: begin
                bulk_busy = 1'b1;
                w_seq_we  = 1'b1;
                w_half    = HALF_LO;
            end
            ST_WRITE_HI: begin
                bulk_busy = 1'b1;
                w_seq_we  = 1'b1;
                w_half    = HALF_HI;
            end
            ST_DONE: begin
                bulk_busy = 1'b1;
            end
            default: begin
                bulk_busy = 1'b0;
            end
        endcase
    end

    // Address and remaining-count tracking, loaded on start and stepped per write
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_start) begin
            r_addr      <= bulk_start_addr;
            r_remaining <= bulk_length;
        end else if (w_write_fire) begin
            r_addr      <= r_addr + ADDR_BITS'(1);
            r_remaining <= r_remaining - ADDR_BITS'(1);
        end
    end

    // Capture each accepted beat together with its end-of-packet marker
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_beat <= '0;
            r_last <= 1'b0;
        end else if (w_beat_accept) begin
            r_beat <= s_axis_tdata;
            r_last <= s_axis_tlast;
        end
    end

    // Sticky tlast-mismatch flag: missing tlast on the final beat, or tlast on an earlier beat
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_error <= 1'b0;
        end else if (w_start) begin
            r_error <= 1'b0;
        end else if (w_beat_accept && w_beat_has_final && !s_axis_tlast) begin
            r_error <= 1'b1;
        end else if (w_write_fire && w_early_last) begin
            r_error <= 1'b1;
        end
    end

    // Count of bulk weights written since the last accepted start
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_written <= '0;
        end else if (w_start) begin
            r_written <= '0;
        end else if (w_write_fire) begin
            r_written <= r_written + 16'd1;
        end
    end

    // One-cycle completion pulse issued as the FSM leaves DONE
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_bulk_done <= 1'b0;
        end else begin
            r_bulk_done <= (r_state == ST_DONE);
        end
    end

    assign bulk_done       = r_bulk_done;
    assign bulk_error      = r_error;
    assign weights_written = r_written;

    weight_port_arbiter #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .ADDR_BITS    (ADDR_BITS)
    ) u_arbiter (
        .i_aclk       (aclk),
        .i_areset     (areset),
        .i_host_we    (host_we),
        .i_host_rd_en (host_rd_en),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .i_seq_we     (w_seq_we),
        .i_seq_addr   (r_addr),
        .i_seq_wdata  (w_seq_wdata),
        .o_mem_we     (mem_we),
        .o_mem_rd_en  (mem_rd_en),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_weight_bulk_sequencer.sv
// Self-checking bench for weight_bulk_sequencer: directed loads plus randomized
// loads with host-read noise, checked against a load-level reference model.
module tb_weight_bulk_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        bulk_start;
    logic [11:0] bulk_start_addr;
    logic [11:0] bulk_length;
    logic        bulk_done;
    logic        bulk_busy;
    logic        bulk_error;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        host_we;
    logic        host_rd_en;
    logic [11:0] host_addr;
    logic [15:0] host_wdata;
    logic        mem_we;
    logic        mem_rd_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] weights_written;

    weight_bulk_sequencer #(
        .WEIGHT_WIDTH (16),
        .ADDR_BITS    (12),
        .STREAM_WIDTH (32)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .bulk_start      (bulk_start),
        .bulk_start_addr (bulk_start_addr),
        .bulk_length     (bulk_length),
        .bulk_done       (bulk_done),
        .bulk_busy       (bulk_busy),
        .bulk_error      (bulk_error),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .host_we         (host_we),
        .host_rd_en      (host_rd_en),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .mem_we          (mem_we),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .weights_written (weights_written)
    );

    // Free-running clock
    always #5 aclk = ~aclk;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        int          edgeNum;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          edgeCount = 0;
    int          doneCount = 0;
    int          readyCount = 0;
    int          readCount = 0;
    int          hostReadsIssued = 0;
    bit          hostNoise = 1'b0;
    int          lastStartEdge;
    int          lastDoneEdge;
    wr_t         obsQ[$];
    logic [31:0] beatMem [0:15];

    // Number every rising edge so observed writes can be placed in time
    always @(posedge aclk) edgeCount <= edgeCount + 1;

    // Passive monitor of the memory port and status pulses, sampled mid-cycle
    always @(negedge aclk) begin
        if (mem_we) obsQ.push_back('{mem_addr, mem_wdata, edgeCount});
        if (mem_rd_en) readCount++;
        if (bulk_done) doneCount++;
        if (s_axis_tready) readyCount++;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, landing 1ns after the edge; optionally inject host reads
    task automatic step();
        @(posedge aclk);
        #1;
        if (hostNoise) begin
            host_rd_en = ($urandom_range(0, 3) == 0);
            host_addr  = 12'($urandom);
            if (host_rd_en) hostReadsIssued++;
        end else begin
            host_rd_en = 1'b0;
        end
    endtask

    // Present one beat and hold it until the sequencer takes it
    task automatic sendBeat(input string tag, input logic [31:0] data, input bit last);
        bit accepted;
        accepted      = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        for (int c = 0; c < 200; c++) begin
            if (s_axis_tready) begin
                step();
                accepted = 1'b1;
                break;
            end
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checkOutput({tag, "_beat_accept"}, 32'(accepted), 32'd1);
    endtask

    // Wait for the completion pulse and check the final status it reports
    task automatic waitDone(input string tag, input bit expErr, input int expWritten);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (bulk_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        lastDoneEdge = edgeCount;
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_error"}, 32'(bulk_error), 32'(expErr));
        checkOutput({tag, "_written"}, 32'(weights_written), 32'(expWritten));
        checkOutput({tag, "_busy_after"}, 32'(bulk_busy), 32'd0);
    endtask

    // Run one bulk load from beatMem and check it against the load-level model
    task automatic applyStimulus(input string tag, input logic [11:0] startAddr, input int len,
                                 input int lastIdx, input int gapMax, input bit spuriousStart);
        int          needed;
        int          sendBeats;
        int          expWrites;
        bit          expErr;
        int          base;
        int          doneBase;
        int          got;
        logic [11:0] ea;
        logic [31:0] bw;
        logic [15:0] ed;

        needed = (len + 1) / 2;
        if (lastIdx >= 0 && lastIdx < needed - 1) begin
            sendBeats = lastIdx + 1;
            expWrites = 2 * (lastIdx + 1);
            expErr    = 1'b1;
        end else begin
            sendBeats = needed;
            expWrites = len;
            expErr    = (lastIdx != needed - 1);
        end

        base     = obsQ.size();
        doneBase = doneCount;

        bulk_start      = 1'b1;
        bulk_start_addr = startAddr;
        bulk_length     = 12'(len);
        lastStartEdge   = edgeCount;
        step();
        bulk_start = 1'b0;
        checkOutput({tag, "_busy"}, 32'(bulk_busy), 32'd1);

        if (spuriousStart) begin
            bulk_start      = 1'b1;
            bulk_start_addr = 12'h777;
            bulk_length     = 12'd1;
            step();
            bulk_start = 1'b0;
        end

        for (int b = 0; b < sendBeats; b++) begin
            repeat ($urandom_range(0, gapMax)) step();
            sendBeat(tag, beatMem[b], (b == lastIdx));
        end

        waitDone(tag, expErr, expWrites);
        repeat (3) step();
        checkOutput({tag, "_done_pulses"}, 32'(doneCount - doneBase), 32'd1);

        got = obsQ.size() - base;
        checkOutput({tag, "_nwrites"}, 32'(got), 32'(expWrites));
        for (int i = 0; i < expWrites && i < got; i++) begin
            ea = startAddr + 12'(i);
            bw = beatMem[i / 2];
            ed = (i % 2 == 1) ? bw[31:16] : bw[15:0];
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(obsQ[base + i].addr), 32'(ea));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(obsQ[base + i].data), 32'(ed));
        end
    endtask

    initial begin
        int          base;
        int          acceptEdge;
        int          doneBase;
        int          readyBase;
        int          readBase;
        int          issuedBase;
        int          len;
        int          needed;
        int          lastIdx;
        int          r;
        logic [11:0] addr;

        areset          = 1'b1;
        bulk_start      = 1'b0;
        bulk_start_addr = '0;
        bulk_length     = '0;
        s_axis_tdata    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        host_we         = 1'b0;
        host_rd_en      = 1'b0;
        host_addr       = '0;
        host_wdata      = '0;

        #1;
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_busy", 32'(bulk_busy), 32'd0);
        checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("rst_written", 32'(weights_written), 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        step();

        $display("[TB] basic load");
        beatMem[0] = 32'h0002_0001;
        beatMem[1] = 32'h0004_0003;
        applyStimulus("basic", 12'h010, 4, 1, 0, 1'b0);

        $display("[TB] address wrap with odd length");
        for (int i = 0; i < 16; i++) beatMem[i] = $urandom;
        applyStimulus("wrap", 12'hFFE, 3, 1, 1, 1'b0);

        $display("[TB] early tlast");
        applyStimulus("early", 12'h300, 6, 0, 0, 1'b0);

        $display("[TB] missing tlast");
        applyStimulus("notlast", 12'h400, 4, -1, 0, 1'b0);

        $display("[TB] start while busy is ignored");
        applyStimulus("busystart", 12'h040, 4, 1, 1, 1'b1);

        $display("[TB] zero length");
        readyBase = readyCount;
        applyStimulus("len0", 12'h123, 0, -1, 0, 1'b0);
        checkOutput("len0_latency", 32'(lastDoneEdge - lastStartEdge), 32'd2);
        checkOutput("len0_tready", 32'(readyCount - readyBase), 32'd0);

        $display("[TB] host write beats host read");
        host_we    = 1'b1;
        host_rd_en = 1'b1;
        host_addr  = 12'h055;
        host_wdata = 16'h1234;
        step();
        host_we = 1'b0;
        checkOutput("hostboth_we", 32'(mem_we), 32'd1);
        checkOutput("hostboth_rd", 32'(mem_rd_en), 32'd0);
        checkOutput("hostboth_addr", 32'(mem_addr), 32'h055);
        checkOutput("hostboth_data", 32'(mem_wdata), 32'h1234);
        host_rd_en = 1'b1;
        host_addr  = 12'h0AA;
        step();
        checkOutput("hostrd_rd", 32'(mem_rd_en), 32'd1);
        checkOutput("hostrd_we", 32'(mem_we), 32'd0);
        checkOutput("hostrd_addr", 32'(mem_addr), 32'h0AA);
        step();

        $display("[TB] host writes stall the sequencer");
        beatMem[0] = 32'hBBBB_AAAA;
        bulk_start      = 1'b1;
        bulk_start_addr = 12'h100;
        bulk_length     = 12'd2;
        step();
        bulk_start = 1'b0;
        base = obsQ.size();
        sendBeat("stall", beatMem[0], 1'b1);
        acceptEdge = edgeCount;
        for (int k = 0; k < 3; k++) begin
            host_we    = 1'b1;
            host_addr  = 12'h300 + 12'(k);
            host_wdata = 16'hC000 + 16'(k);
            step();
        end
        host_we = 1'b0;
        waitDone("stall", 1'b0, 2);
        step();
        checkOutput("stall_nwrites", 32'(obsQ.size() - base), 32'd5);
        if (obsQ.size() - base == 5) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("stall_host%0d_addr", k), 32'(obsQ[base + k].addr), 32'h300 + k);
                checkOutput($sformatf("stall_host%0d_data", k), 32'(obsQ[base + k].data), 32'hC000 + k);
            end
            checkOutput("stall_lo_addr", 32'(obsQ[base + 3].addr), 32'h100);
            checkOutput("stall_lo_data", 32'(obsQ[base + 3].data), 32'hAAAA);
            checkOutput("stall_lo_edge", 32'(obsQ[base + 3].edgeNum - acceptEdge), 32'd4);
            checkOutput("stall_hi_addr", 32'(obsQ[base + 4].addr), 32'h101);
            checkOutput("stall_hi_data", 32'(obsQ[base + 4].data), 32'hBBBB);
        end

        $display("[TB] reset in the middle of a load");
        for (int i = 0; i < 16; i++) beatMem[i] = $urandom;
        bulk_start      = 1'b1;
        bulk_start_addr = 12'h200;
        bulk_length     = 12'd8;
        step();
        bulk_start = 1'b0;
        sendBeat("rstmid", beatMem[0], 1'b0);
        step();
        checkOutput("rstmid_pre_we", 32'(mem_we), 32'd1);
        checkOutput("rstmid_pre_written", 32'(weights_written), 32'd1);
        doneBase = doneCount;
        #3;
        areset = 1'b1;
        #1;
        checkOutput("rstmid_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rstmid_mem_rd", 32'(mem_rd_en), 32'd0);
        checkOutput("rstmid_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rstmid_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rstmid_done", 32'(bulk_done), 32'd0);
        checkOutput("rstmid_busy", 32'(bulk_busy), 32'd0);
        checkOutput("rstmid_error", 32'(bulk_error), 32'd0);
        checkOutput("rstmid_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("rstmid_written", 32'(weights_written), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (10) step();
        checkOutput("rstmid_no_done", 32'(doneCount - doneBase), 32'd0);
        applyStimulus("afterrst", 12'h200, 8, 3, 1, 1'b0);

        $display("[TB] randomized loads with host read noise");
        readBase   = readCount;
        issuedBase = hostReadsIssued;
        hostNoise  = 1'b1;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 16; i++) beatMem[i] = $urandom;
            len    = $urandom_range(1, 12);
            needed = (len + 1) / 2;
            r      = $urandom_range(0, 5);
            if (r == 0) begin
                lastIdx = -1;
            end else if (r == 1 && needed > 1) begin
                lastIdx = $urandom_range(0, needed - 2);
            end else begin
                lastIdx = needed - 1;
            end
            addr = (n % 3 == 0) ? (12'hFF8 + 12'($urandom_range(0, 7))) : 12'($urandom);
            applyStimulus($sformatf("rand%0d", n), addr, len, lastIdx, 2, 1'b0);
        end
        hostNoise = 1'b0;
        repeat (3) step();
        checkOutput("rand_host_reads", 32'(readCount - readBase), 32'(hostReadsIssued - issuedBase));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
